// File: rtl/test_signal_gen.sv
// ----------------------------------------------------------------------------
// test_signal_gen
//   Programmable dual-channel square-wave generator used as the stimulus
//   source for the frequency meter (self-test and calibration).
//   Channel A (o_fx_out) is high for H of every P clock cycles. Channel B
//   (o_fxb_out) has the same period and high time, and its rising edge
//   trails A's by D cycles. A run is either continuous (N = 0) or a burst
//   of N periods. A run can also be ended by stop, which lets the current
//   period finish first.
//
// Ports
//   i_clk          system clock, all logic on the rising edge
//   i_rst          asynchronous active-high reset
//   i_load         1-cycle pulse: capture the *_cfg inputs
//   i_period_cfg   period P (clk cycles)
//   i_high_cfg     high time H (clk cycles)
//   i_delay_cfg    channel-B delay D (clk cycles)
//   i_burst_cfg    periods per run N, 0 = continuous
//   i_start        1-cycle pulse: begin generation
//   i_stop         1-cycle pulse: finish the current period, then halt
//   o_fx_out       channel A square wave (registered)
//   o_fxb_out      channel B square wave (registered)
//   o_running      1 while a run is in progress
//   o_done         1-cycle pulse when a run ends
//   o_cfg_err      1-cycle pulse when a load is rejected
//   o_period_cnt   completed periods in the current or last run
// ----------------------------------------------------------------------------
module test_signal_gen #(
    parameter int W          = 32,
    parameter int DEF_PERIOD = 200,
    parameter int DEF_HIGH   = 100,
    parameter int DEF_DELAY  = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_period_cfg,
    input  logic [W-1:0] i_high_cfg,
    input  logic [W-1:0] i_delay_cfg,
    input  logic [W-1:0] i_burst_cfg,
    input  logic         i_start,
    input  logic         i_stop,
    output logic         o_fx_out,
    output logic         o_fxb_out,
    output logic         o_running,
    output logic         o_done,
    output logic         o_cfg_err,
    output logic [W-1:0] o_period_cnt
);

    localparam logic [W-1:0] ZERO  = {W{1'b0}};
    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] TWO   = W'(2);
    localparam logic [W-1:0] DEF_P = W'(DEF_PERIOD);
    localparam logic [W-1:0] DEF_H = W'(DEF_HIGH);
    localparam logic [W-1:0] DEF_D = W'(DEF_DELAY);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    // Starting value of the B counter, (P - D) mod P, valid because D < P.
    function automatic logic [W-1:0] b_start(input logic [W-1:0] p, input logic [W-1:0] d);
        return (d == ZERO) ? ZERO : (p - d);
    endfunction

    state_t       r_state;
    logic [W-1:0] r_p, r_h, r_d, r_n;          // active config
    logic [W-1:0] r_pp, r_ph, r_pd, r_pn;      // pending config (loaded during RUN)
    logic         r_pend_valid, r_pn_valid;
    logic [W-1:0] r_a_cnt, r_b_cnt, r_period_cnt;
    logic         r_b_armed, r_stop_req;
    logic         r_fx, r_fxb, r_running, r_done, r_cfg_err;

    logic         w_cfg_ok, w_load_ok, w_load_bad;
    logic [W-1:0] w_sp, w_sh, w_sd, w_sn;      // config a start in IDLE would use
    logic         w_a_wrap, w_b_wrap, w_end;
    logic [W-1:0] w_cnt_inc, w_nh, w_a_next, w_b_next;
    logic         w_armed_next, w_fx_next, w_fxb_next;

    // Load validation, start config selection and next-cycle counter/output values in RUN.
    always_comb begin
        w_cfg_ok   = (i_period_cfg >= TWO) && (i_high_cfg != ZERO) &&
                     (i_high_cfg < i_period_cfg) && (i_delay_cfg < i_period_cfg);
        w_load_ok  = i_load & w_cfg_ok;
        w_load_bad = i_load & ~w_cfg_ok;

        // A load in the same cycle as start takes effect for that start.
        if (w_load_ok) begin
            w_sp = i_period_cfg;
            w_sh = i_high_cfg;
            w_sd = i_delay_cfg;
            w_sn = i_burst_cfg;
        end else begin
            w_sp = r_p;
            w_sh = r_h;
            w_sd = r_d;
            w_sn = r_n;
        end

        w_a_wrap  = (r_a_cnt == (r_p - ONE));
        w_b_wrap  = (r_b_cnt == (r_p - ONE));
        w_cnt_inc = r_period_cnt + ONE;
        // A stop arriving on the wrap edge belongs to the period that just finished.
        w_end     = w_a_wrap && (r_stop_req || i_stop ||
                                 ((r_n != ZERO) && (w_cnt_inc == r_n)));

        if (w_a_wrap && r_pend_valid) begin
            // New config starts at the period boundary; B re-runs its delay.
            w_nh         = r_ph;
            w_a_next     = ZERO;
            w_b_next     = b_start(r_pp, r_pd);
            w_armed_next = (r_pd == ZERO);
        end else begin
            w_nh         = r_h;
            w_a_next     = w_a_wrap ? ZERO : (r_a_cnt + ONE);
            w_b_next     = w_b_wrap ? ZERO : (r_b_cnt + ONE);
            w_armed_next = r_b_armed | w_b_wrap;
        end

        w_fx_next  = (w_a_next < w_nh);
        w_fxb_next = w_armed_next & (w_b_next < w_nh);
    end

    // Control FSM, config registers, phase counters and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_p          <= DEF_P;
            r_h          <= DEF_H;
            r_d          <= DEF_D;
            r_n          <= ZERO;
            r_pp         <= ZERO;
            r_ph         <= ZERO;
            r_pd         <= ZERO;
            r_pn         <= ZERO;
            r_pend_valid <= 1'b0;
            r_pn_valid   <= 1'b0;
            r_a_cnt      <= ZERO;
            r_b_cnt      <= ZERO;
            r_period_cnt <= ZERO;
            r_b_armed    <= 1'b0;
            r_stop_req   <= 1'b0;
            r_fx         <= 1'b0;
            r_fxb        <= 1'b0;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= w_load_bad;
            case (r_state)
                ST_IDLE: begin
                    if (w_load_ok) begin
                        r_p <= i_period_cfg;
                        r_h <= i_high_cfg;
                        r_d <= i_delay_cfg;
                        r_n <= i_burst_cfg;
                    end
                    // Stop in the same cycle as start keeps the generator idle.
                    if (i_start && !i_stop) begin
                        r_state      <= ST_RUN;
                        r_running    <= 1'b1;
                        r_a_cnt      <= ZERO;
                        r_b_cnt      <= b_start(w_sp, w_sd);
                        r_b_armed    <= (w_sd == ZERO);
                        r_fx         <= 1'b1;
                        r_fxb        <= (w_sd == ZERO);
                        r_period_cnt <= ZERO;
                        r_stop_req   <= 1'b0;
                        r_pend_valid <= 1'b0;
                        r_pn_valid   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_load_ok) begin
                        r_pp         <= i_period_cfg;
                        r_ph         <= i_high_cfg;
                        r_pd         <= i_delay_cfg;
                        r_pn         <= i_burst_cfg;
                        r_pend_valid <= 1'b1;
                        r_pn_valid   <= 1'b1;
                    end
                    if (i_stop) begin
                        r_stop_req <= 1'b1;
                    end
                    if (w_a_wrap) begin
                        r_period_cnt <= w_cnt_inc;
                        if (r_pend_valid) begin
                            r_p <= r_pp;
                            r_h <= r_ph;
                            r_d <= r_pd;
                            if (!w_load_ok) begin
                                r_pend_valid <= 1'b0;
                            end
                        end
                    end
                    if (w_end) begin
                        // Anything still pending becomes the config for the next run.
                        r_state      <= ST_IDLE;
                        r_running    <= 1'b0;
                        r_fx         <= 1'b0;
                        r_fxb        <= 1'b0;
                        r_done       <= 1'b1;
                        r_stop_req   <= 1'b0;
                        r_pend_valid <= 1'b0;
                        r_pn_valid   <= 1'b0;
                        if (w_load_ok) begin
                            r_p <= i_period_cfg;
                            r_h <= i_high_cfg;
                            r_d <= i_delay_cfg;
                            r_n <= i_burst_cfg;
                        end else begin
                            if (r_pn_valid) begin
                                r_n <= r_pn;
                            end
                        end
                    end else begin
                        r_a_cnt   <= w_a_next;
                        r_b_cnt   <= w_b_next;
                        r_b_armed <= w_armed_next;
                        r_fx      <= w_fx_next;
                        r_fxb     <= w_fxb_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_fx_out     = r_fx;
    assign o_fxb_out    = r_fxb;
    assign o_running    = r_running;
    assign o_done       = r_done;
    assign o_cfg_err    = r_cfg_err;
    assign o_period_cnt = r_period_cnt;

endmodule

// File: tb/tb_test_signal_gen.sv
// ----------------------------------------------------------------------------
// tb_test_signal_gen
//   Directed self-checking bench for test_signal_gen. Inputs change 1 ns after
//   the rising edge and outputs are sampled at the same point, so sample i
//   (i = 0 right after the start edge) shows output cycle i+1.
// ----------------------------------------------------------------------------
module tb_test_signal_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, start, stop;
    logic [31:0] period_cfg, high_cfg, delay_cfg, burst_cfg;
    logic        fx_out, fxb_out, running, done, cfg_err;
    logic [31:0] period_cnt;

    int n_cmp = 0;
    int n_err = 0;

    test_signal_gen #(.W(32), .DEF_PERIOD(200), .DEF_HIGH(100), .DEF_DELAY(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_load(load),
        .i_period_cfg(period_cfg), .i_high_cfg(high_cfg),
        .i_delay_cfg(delay_cfg), .i_burst_cfg(burst_cfg),
        .i_start(start), .i_stop(stop),
        .o_fx_out(fx_out), .o_fxb_out(fxb_out), .o_running(running),
        .o_done(done), .o_cfg_err(cfg_err), .o_period_cnt(period_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int p, input int h, input int d, input int n);
        period_cfg = p; high_cfg = h; delay_cfg = d; burst_cfg = n;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int errs, highs, rises;
    logic prev_fx;

    initial begin
        rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
        period_cfg = 0; high_cfg = 0; delay_cfg = 0; burst_cfg = 0;
        tick(); tick();
        check_val("rst_fx", fx_out, 0);
        check_val("rst_fxb", fxb_out, 0);
        check_val("rst_running", running, 0);
        check_val("rst_done", done, 0);
        check_val("rst_cfg_err", cfg_err, 0);
        check_val("rst_pcnt", period_cnt, 0);
        rst = 1'b0;
        tick();

        // Continuous P=10 H=5 D=0, then stop mid-period.
        do_load(10, 5, 0, 0);
        check_val("t1_cfg_err", cfg_err, 0);
        do_start();
        for (int i = 0; i < 25; i++) begin
            if (i > 0) tick();
            check_val("t1_fx", fx_out, ((i % 10) < 5) ? 1 : 0);
            check_val("t1_fxb", fxb_out, ((i % 10) < 5) ? 1 : 0);
            check_val("t1_pcnt", period_cnt, i / 10);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("t1_run_after_stop", running, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t1_run_finishing", running, 1);
            check_val("t1_no_done", done, 0);
        end
        tick();
        check_val("t1_done", done, 1);
        check_val("t1_running_end", running, 0);
        check_val("t1_fx_end", fx_out, 0);
        check_val("t1_pcnt_end", period_cnt, 3);
        tick();
        check_val("t1_done_pulse", done, 0);
        check_val("t1_pcnt_hold", period_cnt, 3);

        // P=8 H=2 D=3: B rises 3 cycles after A; stop on a wrap edge ends at once.
        do_load(8, 2, 3, 0);
        do_start();
        for (int i = 0; i < 24; i++) begin
            if (i > 0) tick();
            check_val("t2_fx", fx_out, ((i % 8) < 2) ? 1 : 0);
            check_val("t2_fxb", fxb_out, ((i >= 3) && (((i - 3) % 8) < 2)) ? 1 : 0);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("t2_done", done, 1);
        check_val("t2_fxb_end", fxb_out, 0);
        check_val("t2_pcnt", period_cnt, 3);

        // Burst P=20 H=4 N=3: exactly 3 A pulses, done right after the 60th cycle.
        do_load(20, 4, 0, 3);
        do_start();
        rises = 0; errs = 0; prev_fx = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) tick();
            if (fx_out && !prev_fx) rises++;
            prev_fx = fx_out;
            if (!running || done) errs++;
        end
        check_val("t3_rises", rises, 3);
        check_val("t3_run_whole", errs, 0);
        tick();
        check_val("t3_done", done, 1);
        check_val("t3_running", running, 0);
        check_val("t3_pcnt", period_cnt, 3);
        tick();
        check_val("t3_done_pulse", done, 0);
        check_val("t3_pcnt_hold", period_cnt, 3);

        // Rejected loads leave the 20/4/0/N=3 config in place.
        do_load(1, 1, 0, 0);
        check_val("t4_err_p1", cfg_err, 1);
        tick();
        check_val("t4_err_pulse", cfg_err, 0);
        do_load(10, 0, 0, 0);
        check_val("t4_err_h0", cfg_err, 1);
        do_load(10, 10, 0, 0);
        check_val("t4_err_hp", cfg_err, 1);
        do_load(10, 5, 10, 0);
        check_val("t4_err_dp", cfg_err, 1);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check_val("t4_start_stop_idle", running, 0);
        check_val("t4_err_clear", cfg_err, 0);
        do_start();
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) tick();
            if (fx_out !== (((i % 20) < 4) ? 1'b1 : 1'b0)) errs++;
            if (fxb_out !== (((i % 20) < 4) ? 1'b1 : 1'b0)) errs++;
        end
        check_val("t4_old_cfg_wave", errs, 0);
        tick();
        check_val("t4_done", done, 1);
        check_val("t4_pcnt", period_cnt, 3);

        // Load P=6 H=3 during a P=10 run: takes effect at the next period boundary.
        do_load(10, 5, 0, 0);
        do_start();
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                if (i == 4) begin
                    period_cfg = 6; high_cfg = 3; delay_cfg = 0; burst_cfg = 0;
                end
                load = (i == 4);
                tick();
                load = 1'b0;
            end
            if (i == 4) check_val("t5_cfg_err", cfg_err, 0);
            check_val("t5_fx", fx_out, (i < 10) ? ((i < 5) ? 1 : 0) : ((((i - 10) % 6) < 3) ? 1 : 0));
            check_val("t5_fxb", fxb_out, (i < 10) ? ((i < 5) ? 1 : 0) : ((((i - 10) % 6) < 3) ? 1 : 0));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("t5_run_a", running, 1);
        tick();
        check_val("t5_run_b", running, 1);
        tick();
        check_val("t5_done", done, 1);
        check_val("t5_pcnt", period_cnt, 3);

        // Reset mid-high: outputs drop without a clock edge, defaults restored.
        do_load(10, 5, 0, 0);
        do_start();
        tick(); tick();
        check_val("t6_fx_pre", fx_out, 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_fx_rst", fx_out, 0);
        check_val("t6_fxb_rst", fxb_out, 0);
        check_val("t6_running_rst", running, 0);
        check_val("t6_done_rst", done, 0);
        tick();
        rst = 1'b0;
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || running) errs++;
        end
        check_val("t6_quiet", errs, 0);
        do_start();
        highs = 0; errs = 0;
        for (int i = 0; i < 200; i++) begin
            if (i > 0) tick();
            if (fx_out) highs++;
            if (fxb_out !== fx_out) errs++;
        end
        check_val("t6_def_high", highs, 100);
        check_val("t6_def_fxb", errs, 0);
        check_val("t6_def_last_low", fx_out, 0);
        tick();
        check_val("t6_def_wrap_fx", fx_out, 1);
        check_val("t6_def_pcnt", period_cnt, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Let the default-config run finish, then load and start together.
        errs = 1;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (done) begin
                errs = 0;
                break;
            end
        end
        check_val("t7_prev_run_done", errs, 0);
        period_cfg = 4; high_cfg = 1; delay_cfg = 0; burst_cfg = 2;
        load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            check_val("t7_fx", fx_out, ((i % 4) < 1) ? 1 : 0);
        end
        tick();
        check_val("t7_done", done, 1);
        check_val("t7_pcnt", period_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
